// File: rtl/uart_txfifo_pkg.sv
// Shared definitions for the UART transmit FIFO: FSM state encoding and data width.
package uart_txfifo_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_txfifo_mem.sv
// DEPTH x 8 storage with synchronous write and an enabled, registered read port.
// The read register doubles as the byte presented to uart_tx.
module uart_txfifo_mem
  import uart_txfifo_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only loaded on a pop, so the output stays stable for the whole transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_txfifo.sv
// Byte FIFO feeding uart_tx: accepts pushes at any rate and pops one byte per
// uart_tx idle period, issuing a one-cycle start pulse with the byte on data.
module uart_txfifo
  import uart_txfifo_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overrun,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              start,
  output logic [1:0]        fsm_state
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  tx_state_t     state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_nxt;
  logic          push, pop;

  // Handshake: a push is taken when wr=1 and full=0 at the edge; a pop happens
  // only in IDLE with a non-empty FIFO and ready=1 from uart_tx. Both use the
  // registered flags, so a simultaneous pop never makes room for a push.
  assign push = wr && !full;
  assign pop  = (state == IDLE) && !empty && ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      overrun <= 1'b0;
      start   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      full    <= (count_nxt == DEPTH);
      empty   <= (count_nxt == '0);
      overrun <= overrun || (wr && full);
      start   <= pop;
    end
  end

  uart_txfifo_mem #(.AW(AW)) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // BUSY waits for uart_tx to take the byte, DRAIN waits for its stop bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop)    state_nxt = BUSY;
      BUSY:    if (!ready) state_nxt = DRAIN;
      DRAIN:   if (ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fsm_state = state;

endmodule
